// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side inputs, forward sources and EX-side outputs of the ID/EX stage
interface id_ex_stage_if #(parameter int XLEN = 64);
    logic            id_valid;
    logic [4:0]      id_rs1_idx, id_rs2_idx;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic            id_alu_src;
    logic [3:0]      id_alu_control;
    logic [4:0]      id_rd_idx;
    logic            id_reg_write, id_mem_read, id_mem_write;
    logic            exmem_reg_write;
    logic [4:0]      exmem_rd;
    logic [XLEN-1:0] exmem_result;
    logic            memwb_reg_write;
    logic [4:0]      memwb_rd;
    logic [XLEN-1:0] memwb_result;
    logic            hold, flush;
    logic            id_stall, ex_valid;
    logic [XLEN-1:0] alu_a, alu_b, ex_store_data;
    logic [3:0]      alu_control;
    logic [4:0]      ex_rd_idx;
    logic            ex_reg_write, ex_mem_read, ex_mem_write;

    modport master (
        output id_valid, id_rs1_idx, id_rs2_idx, id_rs1_data, id_rs2_data, id_imm,
               id_alu_src, id_alu_control, id_rd_idx, id_reg_write, id_mem_read, id_mem_write,
               exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result,
               hold, flush,
        input  id_stall, ex_valid, alu_a, alu_b, ex_store_data, alu_control, ex_rd_idx,
               ex_reg_write, ex_mem_read, ex_mem_write
    );

    modport slave (
        input  id_valid, id_rs1_idx, id_rs2_idx, id_rs1_data, id_rs2_data, id_imm,
               id_alu_src, id_alu_control, id_rd_idx, id_reg_write, id_mem_read, id_mem_write,
               exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result,
               hold, flush,
        output id_stall, ex_valid, alu_a, alu_b, ex_store_data, alu_control, ex_rd_idx,
               ex_reg_write, ex_mem_read, ex_mem_write
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and load-use bubble insertion
module id_ex_stage #(parameter int XLEN = 64) (
    input  logic         clk,
    input  logic         reset,
    id_ex_stage_if.slave bus
);
    logic            v, alu_src, rw, mr, mw;
    logic [4:0]      rs1_idx, rs2_idx, rd;
    logic [XLEN-1:0] rs1_d, rs2_d, imm, rs1_fwd, rs2_fwd;
    logic [3:0]      ctl;
    logic            load_use;

    function automatic logic hit(input logic we, input logic [4:0] dst, input logic [4:0] idx);
        return we && dst != 5'd0 && dst == idx;
    endfunction

    assign load_use = v && mr && rd != 5'd0 && bus.id_valid &&
                      (rd == bus.id_rs1_idx || rd == bus.id_rs2_idx);

    // pipeline register: reset/flush/load-use clear to a bubble, hold freezes, else capture with WB bypass
    always_ff @(posedge clk) begin
        if (reset || bus.flush || (!bus.hold && load_use)) begin
            v       <= 1'b0;
            rs1_idx <= '0;
            rs2_idx <= '0;
            rs1_d   <= '0;
            rs2_d   <= '0;
            imm     <= '0;
            alu_src <= 1'b0;
            ctl     <= '0;
            rd      <= '0;
            rw      <= 1'b0;
            mr      <= 1'b0;
            mw      <= 1'b0;
        end else if (!bus.hold) begin
            v       <= bus.id_valid;
            rs1_idx <= bus.id_rs1_idx;
            rs2_idx <= bus.id_rs2_idx;
            rs1_d   <= hit(bus.memwb_reg_write, bus.memwb_rd, bus.id_rs1_idx) ? bus.memwb_result : bus.id_rs1_data;
            rs2_d   <= hit(bus.memwb_reg_write, bus.memwb_rd, bus.id_rs2_idx) ? bus.memwb_result : bus.id_rs2_data;
            imm     <= bus.id_imm;
            alu_src <= bus.id_alu_src;
            ctl     <= bus.id_alu_control;
            rd      <= bus.id_rd_idx;
            rw      <= bus.id_valid && bus.id_reg_write;
            mr      <= bus.id_valid && bus.id_mem_read;
            mw      <= bus.id_valid && bus.id_mem_write;
        end
    end

    // operand forwarding: EX/MEM result is newer than MEM/WB, so it takes precedence
    always_comb begin
        rs1_fwd = hit(bus.exmem_reg_write, bus.exmem_rd, rs1_idx) ? bus.exmem_result :
                  hit(bus.memwb_reg_write, bus.memwb_rd, rs1_idx) ? bus.memwb_result : rs1_d;
        rs2_fwd = hit(bus.exmem_reg_write, bus.exmem_rd, rs2_idx) ? bus.exmem_result :
                  hit(bus.memwb_reg_write, bus.memwb_rd, rs2_idx) ? bus.memwb_result : rs2_d;
    end

    assign bus.id_stall      = (load_use || bus.hold) && !bus.flush;
    assign bus.ex_valid      = v;
    assign bus.alu_a         = rs1_fwd;
    assign bus.alu_b         = alu_src ? imm : rs2_fwd;
    assign bus.ex_store_data = rs2_fwd;
    assign bus.alu_control   = ctl;
    assign bus.ex_rd_idx     = rd;
    assign bus.ex_reg_write  = rw;
    assign bus.ex_mem_read   = mr;
    assign bus.ex_mem_write  = mw;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed stimulus with a queued scoreboard checked by an independent monitor
module tb_id_ex_stage;
    localparam int XLEN = 64;
    localparam int S_VALID = 0, S_A = 1, S_B = 2, S_CTL = 3, S_ST = 4, S_STALL = 5,
                   S_RW = 6, S_RD = 7, S_MR = 8;

    typedef struct {
        string           name;
        int              sel;
        logic [XLEN-1:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    exp_t q[$];
    int   total = 0;
    int   passed = 0;

    id_ex_stage_if #(.XLEN(XLEN)) bus ();
    id_ex_stage #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] obs(input int s);
        case (s)
            S_VALID: return {63'd0, bus.ex_valid};
            S_A:     return bus.alu_a;
            S_B:     return bus.alu_b;
            S_CTL:   return {60'd0, bus.alu_control};
            S_ST:    return bus.ex_store_data;
            S_STALL: return {63'd0, bus.id_stall};
            S_RW:    return {63'd0, bus.ex_reg_write};
            S_RD:    return {59'd0, bus.ex_rd_idx};
            default: return {63'd0, bus.ex_mem_read};
        endcase
    endfunction

    // monitor: compare every queued expectation against the outputs mid-cycle
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [XLEN-1:0] got;
            e = q.pop_front();
            got = obs(e.sel);
            total++;
            if (got === e.exp) passed++;
            else $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, got, e.exp);
        end
    end

    task automatic expect_val(input string name, input int sel, input logic [XLEN-1:0] v);
        exp_t e;
        e.name = name;
        e.sel = sel;
        e.exp = v;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_idle();
        bus.id_valid = 0; bus.id_rs1_idx = 0; bus.id_rs2_idx = 0;
        bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0;
        bus.id_alu_src = 0; bus.id_alu_control = 0; bus.id_rd_idx = 0;
        bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
    endtask

    task automatic fwd_off();
        bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
        bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
    endtask

    task automatic id_set(input logic [4:0] r1, input logic [XLEN-1:0] d1, input logic [4:0] r2,
                          input logic [XLEN-1:0] d2, input logic [XLEN-1:0] im, input logic src,
                          input logic [3:0] c, input logic [4:0] d, input logic mread);
        bus.id_valid = 1; bus.id_rs1_idx = r1; bus.id_rs1_data = d1;
        bus.id_rs2_idx = r2; bus.id_rs2_data = d2; bus.id_imm = im;
        bus.id_alu_src = src; bus.id_alu_control = c; bus.id_rd_idx = d;
        bus.id_reg_write = 1; bus.id_mem_read = mread; bus.id_mem_write = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        id_idle();
        fwd_off();
        bus.hold = 0;
        bus.flush = 0;
        step();
        step();
        expect_val("rst_valid", S_VALID, 0);
        expect_val("rst_ctl", S_CTL, 0);
        expect_val("rst_a", S_A, 0);
        expect_val("rst_b", S_B, 0);
        expect_val("rst_rw", S_RW, 0);
        reset = 0;
        id_set(5, 10, 6, 20, 0, 0, 4'b0010, 1, 0);
        step();
        bus.exmem_reg_write = 1; bus.exmem_rd = 5; bus.exmem_result = 100;
        bus.memwb_reg_write = 1; bus.memwb_rd = 5; bus.memwb_result = 200;
        bus.hold = 1;
        id_set(5, 99, 6, 98, 0, 0, 4'b0110, 3, 0);
        expect_val("prio_a", S_A, 100);
        expect_val("prio_b", S_B, 20);
        expect_val("prio_ctl", S_CTL, 2);
        expect_val("prio_valid", S_VALID, 1);
        expect_val("prio_st", S_ST, 20);
        expect_val("hold_stall", S_STALL, 1);
        step();
        bus.exmem_reg_write = 0;
        expect_val("memwb_a", S_A, 200);
        expect_val("hold_ctl1", S_CTL, 2);
        expect_val("hold_stall1", S_STALL, 1);
        step();
        bus.memwb_reg_write = 0;
        expect_val("regdata_a", S_A, 10);
        expect_val("hold_rd", S_RD, 1);
        step();
        bus.flush = 1;
        expect_val("flushhold_stall", S_STALL, 0);
        expect_val("hold_ctl3", S_CTL, 2);
        step();
        bus.flush = 0;
        bus.hold = 0;
        id_idle();
        fwd_off();
        expect_val("flush_valid", S_VALID, 0);
        expect_val("flush_ctl", S_CTL, 0);
        expect_val("flush_rw", S_RW, 0);
        expect_val("flush_rd", S_RD, 0);
        id_set(0, 0, 3, 'h33, -64'sd4, 1, 4'b0010, 2, 0);
        step();
        id_idle();
        bus.exmem_reg_write = 1; bus.exmem_rd = 0; bus.exmem_result = 'hFFFF;
        expect_val("x0_a", S_A, 0);
        expect_val("imm_b", S_B, 64'hFFFF_FFFF_FFFF_FFFC);
        expect_val("imm_st", S_ST, 'h33);
        step();
        fwd_off();
        id_set(1, 'h1000, 0, 0, 8, 1, 4'b0010, 7, 1);
        step();
        id_set(7, 0, 0, 0, 0, 0, 4'b0011, 8, 0);
        expect_val("lu_stall", S_STALL, 1);
        expect_val("lu_load_mr", S_MR, 1);
        step();
        expect_val("lu_bubble_valid", S_VALID, 0);
        expect_val("lu_bubble_stall", S_STALL, 0);
        expect_val("lu_bubble_mr", S_MR, 0);
        step();
        id_idle();
        bus.memwb_reg_write = 1; bus.memwb_rd = 7; bus.memwb_result = 'hABC;
        expect_val("lu_dep_valid", S_VALID, 1);
        expect_val("lu_dep_rd", S_RD, 8);
        expect_val("lu_dep_ctl", S_CTL, 3);
        expect_val("lu_dep_a", S_A, 'hABC);
        step();
        fwd_off();
        id_set(1, 'h1000, 0, 0, 8, 1, 4'b0010, 7, 1);
        step();
        id_set(0, 0, 7, 0, 0, 0, 4'b0000, 9, 0);
        bus.hold = 1;
        expect_val("hlu_stall", S_STALL, 1);
        step();
        expect_val("hlu_valid", S_VALID, 1);
        expect_val("hlu_mr", S_MR, 1);
        expect_val("hlu_rd", S_RD, 7);
        bus.flush = 1;
        expect_val("flu_stall", S_STALL, 0);
        step();
        bus.flush = 0;
        bus.hold = 0;
        id_idle();
        expect_val("flu_valid", S_VALID, 0);
        id_set(4, 4, 9, 'h11, 0, 0, 4'b0001, 10, 0);
        bus.memwb_reg_write = 1; bus.memwb_rd = 9; bus.memwb_result = 'h55;
        step();
        fwd_off();
        id_idle();
        expect_val("wb_b", S_B, 'h55);
        expect_val("wb_st", S_ST, 'h55);
        expect_val("wb_a", S_A, 4);
        expect_val("wb_ctl", S_CTL, 1);
        id_set(0, 0, 0, 0, 0, 0, 4'b0100, 5, 1);
        bus.id_valid = 0;
        bus.id_mem_write = 1;
        step();
        id_idle();
        expect_val("inv_valid", S_VALID, 0);
        expect_val("inv_rw", S_RW, 0);
        expect_val("inv_mr", S_MR, 0);
        expect_val("inv_rd", S_RD, 5);
        expect_val("inv_ctl", S_CTL, 4);
        id_set(1, 'h1000, 0, 0, 8, 1, 4'b0010, 7, 1);
        step();
        id_set(7, 0, 0, 0, 0, 0, 4'b0011, 8, 0);
        bus.hold = 1;
        reset = 1;
        expect_val("rstst_stall", S_STALL, 1);
        step();
        reset = 0;
        bus.hold = 0;
        expect_val("rstst_valid", S_VALID, 0);
        expect_val("rstst_mr", S_MR, 0);
        expect_val("rstst_stall2", S_STALL, 0);
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
